// File: rtl/uart_inint_parser_pkg.sv
// Shared types and constants for the ININT ASCII-decimal parser.
package uart_inint_parser_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RESULT_W = 32;
  localparam int unsigned WIDE_W   = 36;

  localparam logic [5:0] FUNC_ININT = 6'h11;

  localparam logic [DATA_W-1:0] ASCII_0     = 8'h30;
  localparam logic [DATA_W-1:0] ASCII_9     = 8'h39;
  localparam logic [DATA_W-1:0] ASCII_MINUS = 8'h2D;
  localparam logic [DATA_W-1:0] ASCII_PLUS  = 8'h2B;
  localparam logic [DATA_W-1:0] ASCII_SP    = 8'h20;
  localparam logic [DATA_W-1:0] ASCII_TAB   = 8'h09;
  localparam logic [DATA_W-1:0] ASCII_LF    = 8'h0A;
  localparam logic [DATA_W-1:0] ASCII_CR    = 8'h0D;
  localparam logic [DATA_W-1:0] ASCII_LC_A  = 8'h61;
  localparam logic [DATA_W-1:0] ASCII_LC_F  = 8'h66;
  localparam logic [DATA_W-1:0] ASCII_UC_A  = 8'h41;
  localparam logic [DATA_W-1:0] ASCII_UC_F  = 8'h46;
  localparam logic [DATA_W-1:0] ASCII_LC_X  = 8'h78;
  localparam logic [DATA_W-1:0] ASCII_UC_X  = 8'h58;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    SIGN,
    DIGIT,
    FIN
  } inint_state_t;

  typedef struct packed {
    logic       is_ws;
    logic       is_dec;
    logic       is_hex;
    logic [3:0] nibble;
  } char_class_t;

  // One accumulation step, kept 36 bits wide so overflow past 32 bits is visible.
  function automatic logic [WIDE_W-1:0] acc_step(input logic [RESULT_W-1:0] acc,
                                                 input logic [3:0]          d,
                                                 input logic                hex);
    logic [WIDE_W-1:0] a;
    a = WIDE_W'(acc);
    if (hex) begin
      return (a << 4) + WIDE_W'(d);
    end
    return (a << 3) + (a << 1) + WIDE_W'(d);
  endfunction

endpackage

// File: rtl/uart_inint_parser_if.sv
// Request/RX-pop/result bundle between execute, RX buffer and the ININT parser.
interface uart_inint_parser_if
  import uart_inint_parser_pkg::*;
  ();

  logic                start;
  logic                rx_valid;
  logic [DATA_W-1:0]   rx_data;
  logic                rx_ready;
  logic                busy;
  logic                done;
  logic [RESULT_W-1:0] result;
  logic                err;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, busy, done, result, err
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, busy, done, result, err
  );

endinterface

// File: rtl/ascii_digit_decode.sv
// Combinational byte classifier: whitespace, decimal digit, hex digit and nibble value.
module ascii_digit_decode
  import uart_inint_parser_pkg::*;
  (
    input  logic [DATA_W-1:0] data_i,
    output char_class_t       cls_c
  );

  always_comb begin
    cls_c = '0;
    cls_c.is_ws = (data_i == ASCII_SP) || (data_i == ASCII_TAB) ||
                  (data_i == ASCII_LF) || (data_i == ASCII_CR);
    if ((data_i >= ASCII_0) && (data_i <= ASCII_9)) begin
      cls_c.is_dec = 1'b1;
      cls_c.is_hex = 1'b1;
      cls_c.nibble = 4'(data_i - ASCII_0);
    end else if ((data_i >= ASCII_LC_A) && (data_i <= ASCII_LC_F)) begin
      cls_c.is_hex = 1'b1;
      cls_c.nibble = 4'(data_i - ASCII_LC_A + 8'd10);
    end else if ((data_i >= ASCII_UC_A) && (data_i <= ASCII_UC_F)) begin
      cls_c.is_hex = 1'b1;
      cls_c.nibble = 4'(data_i - ASCII_UC_A + 8'd10);
    end
  end

endmodule

// File: rtl/uart_inint_parser.sv
// ASCII-decimal to 32-bit integer parser fed from the UART RX byte buffer (ININT).
// Optional hex prefix support ("0x"/"0X") is enabled by defining INININT_HEX_EN.
module uart_inint_parser
  import uart_inint_parser_pkg::*;
  #(
    parameter int unsigned MAX_DIGITS = 10
  )
  (
    input  logic                clk,
    input  logic                rstn,
    uart_inint_parser_if.slave  bus
  );

  localparam int unsigned NDIG_W = $clog2(MAX_DIGITS + 1);

  inint_state_t        state_q, state_d;
  logic [RESULT_W-1:0] acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [NDIG_W-1:0]   ndig_q, ndig_d;
  logic                ovf_q, ovf_d;
  logic                hex_q, hex_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                err_q, err_d;

  char_class_t         cls_c;
  logic                pop_c;
  logic                digit_ok_c;
  logic [WIDE_W-1:0]   wide_c;
  logic                fin_c;
  logic                fin_err_c;

  ascii_digit_decode u_decode (
    .data_i (bus.rx_data),
    .cls_c  (cls_c)
  );

  // Pop strobe is the registered busy flag, so at most one byte per cycle.
  assign pop_c      = bus.rx_valid && busy_q;
  assign digit_ok_c = hex_q ? cls_c.is_hex : cls_c.is_dec;
  assign wide_c     = acc_step(acc_q, cls_c.nibble, hex_q);

  assign bus.rx_ready = busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.err      = err_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    ndig_d    = ndig_q;
    ovf_d     = ovf_q;
    hex_d     = hex_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    err_d     = err_q;
    fin_c     = 1'b0;
    fin_err_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SKIP;
          acc_d   = '0;
          neg_d   = 1'b0;
          ndig_d  = '0;
          ovf_d   = 1'b0;
          hex_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SKIP: begin
        if (pop_c) begin
          if (cls_c.is_ws) begin
            state_d = SKIP;
          end else if (bus.rx_data == ASCII_MINUS) begin
            neg_d   = 1'b1;
            state_d = SIGN;
          end else if (bus.rx_data == ASCII_PLUS) begin
            state_d = SIGN;
          end else if (cls_c.is_dec) begin
            acc_d   = RESULT_W'(cls_c.nibble);
            ndig_d  = NDIG_W'(1);
            state_d = DIGIT;
          end else begin
            fin_c     = 1'b1;
            fin_err_c = 1'b1;
          end
        end
      end
      SIGN: begin
        if (pop_c) begin
          if (cls_c.is_dec) begin
            acc_d   = RESULT_W'(cls_c.nibble);
            ndig_d  = NDIG_W'(1);
            state_d = DIGIT;
          end else begin
            fin_c     = 1'b1;
            fin_err_c = 1'b1;
          end
        end
      end
      DIGIT: begin
        if (pop_c) begin
          if (digit_ok_c) begin
            // A digit beyond the limit is swallowed and ends the parse in error.
            if (ndig_q == NDIG_W'(MAX_DIGITS)) begin
              fin_c     = 1'b1;
              fin_err_c = 1'b1;
            end else begin
              acc_d  = wide_c[RESULT_W-1:0];
              ndig_d = ndig_q + NDIG_W'(1);
              if (|wide_c[WIDE_W-1:RESULT_W]) begin
                ovf_d = 1'b1;
              end
            end
          end
`ifdef INININT_HEX_EN
          else if (!hex_q && (acc_q == '0) && (ndig_q == NDIG_W'(1)) &&
                   ((bus.rx_data == ASCII_LC_X) || (bus.rx_data == ASCII_UC_X))) begin
            hex_d  = 1'b1;
            ndig_d = '0;
          end
`endif
          else begin
            fin_c     = 1'b1;
            fin_err_c = (ndig_q == '0);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Terminator consumed: publish result so done lands in the following cycle.
    if (fin_c) begin
      state_d  = FIN;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      err_d    = ovf_q | fin_err_c;
      result_d = neg_q ? (~acc_q + 32'd1) : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      ndig_q   <= '0;
      ovf_q    <= 1'b0;
      hex_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      ndig_q   <= ndig_d;
      ovf_q    <= ovf_d;
      hex_q    <= hex_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_inint_parser.sv
// Directed table-driven bench for uart_inint_parser with a queue-based RX buffer model.
module tb_uart_inint_parser;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_inint_parser_if bus ();

  uart_inint_parser dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    string       nm;
    string       s;
    int          gap;
    logic [31:0] res;
    logic        err;
    int          pops;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  rxq[$];
  int          gap_cfg = 0;
  int          gap_left = 0;
  logic        popped_evt = 1'b0;
  int          npop = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Pop bookkeeping sampled at the active edge, before DUT state updates.
  always @(posedge clk) begin
    popped_evt <= bus.rx_valid && bus.rx_ready;
    cyc        <= cyc + 1;
    if (bus.rx_valid && bus.rx_ready) begin
      npop         <= npop + 1;
      last_pop_cyc <= cyc;
    end
  end

  // RX buffer model: head byte presented, optional idle gap after every pop.
  initial begin
    logic [7:0] tmp;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (popped_evt && (rxq.size() > 0)) begin
        tmp      = rxq.pop_front();
        gap_left = gap_cfg;
      end else if (gap_left > 0) begin
        gap_left = gap_left - 1;
      end
      bus.rx_valid = (rxq.size() > 0) && (gap_left == 0);
      bus.rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input string s, input int gap,
                         input logic [31:0] res, input logic err, input int pops);
    vec_t v;
    v.nm = nm; v.s = s; v.gap = gap; v.res = res; v.err = err; v.pops = pops;
    vecs.push_back(v);
  endtask

  task automatic load(input string s, input int gap);
    rxq.delete();
    for (int i = 0; i < s.len(); i++) rxq.push_back(8'(s[i]));
    gap_cfg = gap;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  p0;
    bit  seen;
    bit  bdrop;
    logic [31:0] held;
    load(v.s, v.gap);
    p0 = npop;
    pulse_start();
    seen  = 1'b0;
    bdrop = 1'b0;
    for (int k = 0; (k < 300) && !seen; k++) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (!bus.busy) bdrop = 1'b1;
        @(negedge clk);
      end
    end
    chk({v.nm, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({v.nm, " result"}, bus.result, v.res);
      chk({v.nm, " err"}, 32'(bus.err), 32'(v.err));
      chk({v.nm, " pops"}, 32'(npop - p0), 32'(v.pops));
      chk({v.nm, " latency"}, 32'(cyc - last_pop_cyc), 32'd1);
      chk({v.nm, " busy_held"}, 32'(bdrop), 32'd0);
      chk({v.nm, " busy_at_done"}, 32'(bus.busy), 32'd0);
      held = bus.result;
      @(negedge clk);
      chk({v.nm, " done_pulse"}, 32'(bus.done), 32'd0);
      chk({v.nm, " result_held"}, bus.result, held);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   p0;
    int   ndone;
    bit   got;
    bit   bad;

    add_vec("ws_123",     "  123\n",        0, 32'd123,       1'b0, 6);
    add_vec("neg45_gap",  "-45 ",           3, 32'hFFFF_FFD3, 1'b0, 4);
    add_vec("ovf_2p32",   "4294967296\n",   0, 32'h0000_0000, 1'b1, 11);
    add_vec("ovf_5e9",    "5000000000\n",   0, 32'h2A05_F200, 1'b1, 11);
    add_vec("max_u32",    "4294967295\n",   0, 32'hFFFF_FFFF, 1'b0, 11);
    add_vec("min_s32",    "-2147483648\n",  0, 32'h8000_0000, 1'b0, 12);
    add_vec("neg_zero",   "-0\n",           0, 32'd0,         1'b0, 3);
    add_vec("sign_only",  "-\n",            0, 32'd0,         1'b1, 2);
    add_vec("plus_alpha", "+a",             0, 32'd0,         1'b1, 2);
    add_vec("abc",        "abc",            0, 32'd0,         1'b1, 1);
    add_vec("digits_11",  "12345678901\n",  0, 32'h4996_02D2, 1'b1, 11);
    add_vec("ws_mix_9x",  "\t\r\n 9x",      0, 32'd9,         1'b0, 6);
`ifdef INININT_HEX_EN
    add_vec("hex_1f",     "0x1F ",          0, 32'd31,        1'b0, 5);
    add_vec("hex_empty",  "0x\n",           0, 32'd0,         1'b1, 3);
    add_vec("hex_ab_uc",  "0XaB\n",         0, 32'd171,       1'b0, 5);
    add_vec("hex_ffff",   "0xffffffff ",    0, 32'hFFFF_FFFF, 1'b0, 11);
    add_vec("hex_ovf",    "0x100000000 ",   0, 32'd0,         1'b1, 12);
`else
    add_vec("hex_1f",     "0x1F ",          0, 32'd0,         1'b0, 2);
    add_vec("hex_empty",  "0x\n",           0, 32'd0,         1'b0, 2);
    add_vec("hex_ab_uc",  "0XaB\n",         0, 32'd0,         1'b0, 2);
`endif
    add_vec("plus7",      "+7\t",           0, 32'd7,         1'b0, 3);

    bus.start = 1'b0;
    rstn      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset done",     32'(bus.done),     32'd0);
    chk("reset busy",     32'(bus.busy),     32'd0);
    chk("reset rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("reset result",   bus.result,        32'd0);
    chk("reset err",      32'(bus.err),      32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of "1234\n" after two bytes are consumed.
    load("1234\n", 0);
    p0 = npop;
    pulse_start();
    for (int k = 0; (k < 50) && ((npop - p0) < 2); k++) @(negedge clk);
    chk("midrst reached_2_pops", 32'((npop - p0) >= 2), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst done",     32'(bus.done),     32'd0);
    chk("midrst busy",     32'(bus.busy),     32'd0);
    chk("midrst rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("midrst result",   bus.result,        32'd0);
    chk("midrst err",      32'(bus.err),      32'd0);
    rxq.delete();
    @(negedge clk);
    rstn  = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) ndone = ndone + 1;
    end
    chk("midrst no_done", 32'(ndone), 32'd0);
    v.nm = "after_rst"; v.s = "7\n"; v.gap = 0; v.res = 32'd7; v.err = 1'b0; v.pops = 2;
    run_vec(v);

    // Start re-pulsed while busy and again during the done cycle: both ignored.
    load("88\n", 2);
    pulse_start();
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int k = 0; (k < 200) && !got; k++) begin
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    chk("busy_start done_seen", 32'(got), 32'd1);
    ndone = got ? 1 : 0;
    chk("busy_start result", bus.result, 32'd88);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bad = 1'b0;
    p0  = npop;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) load("5\n", 0);
      if (bus.done) ndone = ndone + 1;
      if (bus.busy) bad = 1'b1;
    end
    chk("busy_start single_done", 32'(ndone), 32'd1);
    chk("fin_start ignored_busy", 32'(bad), 32'd0);
    chk("fin_start no_pops", 32'(npop - p0), 32'd0);
    v.nm = "fresh_start"; v.s = "5\n"; v.gap = 0; v.res = 32'd5; v.err = 1'b0; v.pops = 2;
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
